ad9517_spi_target: RTL and testbench

//  3-wire SPI target (responder) that emulates the AD9517 control port: the opposite end of spi_master.

---
 rtl/ad9517_spi_target_pkg.sv | 22 ++
 rtl/ad9517_spi_target_pin_sync.sv | 37 +++
 rtl/ad9517_spi_target.sv | 208 ++++++++++++++++++++
 tb/tb_ad9517_spi_target.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9517_spi_target_pkg.sv
// Shared definitions for the AD9517 control-port emulation: header layout, W1W0 codes, FSM states.
package ad9517_pkg;

    localparam int unsigned INSTR_HEADER_LEN = 16;
    localparam int unsigned ADDR_FIELD_W     = 13;

    typedef enum logic [1:0] {
        W1W0_1BYTE  = 2'b00,
        W1W0_2BYTE  = 2'b01,
        W1W0_3BYTE  = 2'b10,
        W1W0_STREAM = 2'b11
    } w1w0_t;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        WDATA,
        RDATA,
        DONE
    } state_t;

endpackage

// File: rtl/ad9517_spi_target_pin_sync.sv
// Multi-stage synchroniser for one SPI pin, with registered rise/fall detect on the last two samples.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    // Level is the sample the edge decision was made on, so data pins line up with clock edges.
    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ad9517_spi_target.sv
// AD9517-style 3-wire SPI target: oversampled pins, 16-bit header decode, byte regfile with host read port.
module ad9517_spi_target
    import ad9517_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_sdio_i,
    output logic                    spi_sdio_o,
    output logic                    spi_sdio_oe,
    output logic                    o_wr_strobe,
    output logic [ADDR_FIELD_W-1:0] o_wr_addr,
    output logic [7:0]              o_wr_data,
    input  logic [ADDR_W-1:0]       i_host_addr,
    output logic [7:0]              o_host_rdata,
    output logic                    o_frame_done,
    output logic                    o_frame_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_sdio, w_sdio_rise, w_sdio_fall;
    logic w_unused_pins;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_pin(spi_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .i_pin(spi_cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdio (
        .clk(clk), .rst(rst), .i_pin(spi_sdio_i),
        .o_level(w_sdio), .o_rise(w_sdio_rise), .o_fall(w_sdio_fall)
    );

    assign w_unused_pins = ^{w_sclk_lvl, w_cs_lvl, w_sdio_rise, w_sdio_fall};

    state_t                  r_state, w_next;
    logic [14:0]             r_shift;
    logic [3:0]              r_bit_cnt;
    logic [ADDR_FIELD_W-1:0] r_addr;
    logic [1:0]              r_bytes_left;
    logic                    r_stream;
    logic [2:0]              r_dbit;
    logic [2:0]              r_fbit;
    logic [6:0]              r_wbyte;
    logic [7:0]              r_tx;
    logic                    r_oe, r_sdo;
    logic                    r_wr_strobe, r_frame_done, r_frame_err;
    logic [ADDR_FIELD_W-1:0] r_wr_addr;
    logic [7:0]              r_wr_data, r_host_rdata;
    logic [7:0]              r_mem [DEPTH];

    logic [15:0]             w_hdr;
    logic [ADDR_FIELD_W-1:0] w_hdr_addr, w_spi_raddr;
    logic                    w_raddr_ok, w_waddr_ok, w_last_byte, w_byte_end, w_mem_we;
    logic [7:0]              w_spi_rdata, w_wbyte;

    assign w_hdr       = {r_shift, w_sdio};
    assign w_hdr_addr  = w_hdr[ADDR_FIELD_W-1:0];
    // Header completion reads the start address; later reloads read the next (decremented) one.
    assign w_spi_raddr = (r_state == INSTR) ? w_hdr_addr : r_addr - 13'd1;
    assign w_raddr_ok  = 32'(w_spi_raddr) < DEPTH;
    assign w_waddr_ok  = 32'(r_addr) < DEPTH;
    assign w_spi_rdata = w_raddr_ok ? r_mem[w_spi_raddr[ADDR_W-1:0]] : 8'h00;
    assign w_wbyte     = {r_wbyte, w_sdio};
    assign w_last_byte = !r_stream && (r_bytes_left == 2'd0);
    assign w_byte_end  = w_sclk_rise && (r_dbit == 3'd7);
    assign w_mem_we    = !w_cs_rise && (r_state == WDATA) && w_byte_end && w_waddr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_cs_rise) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_cs_fall) w_next = INSTR;
                INSTR:   if (w_sclk_rise && r_bit_cnt == 4'(INSTR_HEADER_LEN - 1))
                             w_next = w_hdr[15] ? RDATA : WDATA;
                WDATA,
                RDATA:   if (w_byte_end && w_last_byte) w_next = DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_addr       <= '0;
            r_bytes_left <= '0;
            r_stream     <= 1'b0;
            r_dbit       <= '0;
            r_fbit       <= '0;
            r_wbyte      <= '0;
            r_tx         <= '0;
            r_oe         <= 1'b0;
            r_sdo        <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_wr_strobe  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_cs_rise) begin
                r_oe  <= 1'b0;
                r_sdo <= 1'b0;
                if (r_state == DONE ||
                    ((r_state == WDATA || r_state == RDATA) && r_stream && r_dbit == 3'd0))
                    r_frame_done <= 1'b1;
                else if (r_state != IDLE)
                    r_frame_err <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: if (w_cs_fall) begin
                        r_bit_cnt <= '0;
                        r_dbit    <= '0;
                        r_fbit    <= '0;
                    end
                    INSTR: if (w_sclk_rise) begin
                        r_shift   <= w_hdr[14:0];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(INSTR_HEADER_LEN - 1)) begin
                            r_addr       <= w_hdr_addr;
                            r_bytes_left <= w_hdr[14:13];
                            r_stream     <= (w1w0_t'(w_hdr[14:13]) == W1W0_STREAM);
                            r_tx         <= w_spi_rdata;
                        end
                    end
                    WDATA: if (w_sclk_rise) begin
                        r_wbyte <= w_wbyte[6:0];
                        r_dbit  <= r_dbit + 3'd1;
                        if (r_dbit == 3'd7) begin
                            r_wr_strobe  <= 1'b1;
                            r_wr_addr    <= r_addr;
                            r_wr_data    <= w_wbyte;
                            r_addr       <= r_addr - 13'd1;
                            r_bytes_left <= r_bytes_left - 2'd1;
                        end
                    end
                    RDATA: begin
                        // Byte count advances on rises (master samples there); data shifts out on falls.
                        if (w_sclk_rise) begin
                            r_dbit <= r_dbit + 3'd1;
                            if (r_dbit == 3'd7) r_bytes_left <= r_bytes_left - 2'd1;
                        end
                        if (w_sclk_fall) begin
                            r_oe   <= 1'b1;
                            r_sdo  <= r_tx[7];
                            r_fbit <= r_fbit + 3'd1;
                            if (r_fbit == 3'd7) begin
                                r_tx   <= w_spi_rdata;
                                r_addr <= r_addr - 13'd1;
                            end else begin
                                r_tx <= {r_tx[6:0], 1'b0};
                            end
                        end
                        if (w_next != RDATA) begin
                            r_oe  <= 1'b0;
                            r_sdo <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[ADDR_W'(i)] <= '0;
        end else if (w_mem_we) begin
            r_mem[r_addr[ADDR_W-1:0]] <= w_wbyte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_host_rdata <= '0;
        else     r_host_rdata <= r_mem[i_host_addr];
    end

    assign spi_sdio_o   = r_sdo;
    assign spi_sdio_oe  = r_oe;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_host_rdata = r_host_rdata;
    assign o_frame_done = r_frame_done;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ad9517_spi_target.sv
// Directed bench for ad9517_spi_target: bench-side SPI master, strobe/frame monitors, host-port readback.
module tb_ad9517_spi_target;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk, spi_cs_n, spi_sdio_i;
    logic        spi_sdio_o, spi_sdio_oe;
    logic        o_wr_strobe, o_frame_done, o_frame_err;
    logic [12:0] o_wr_addr;
    logic [7:0]  o_wr_data, o_host_rdata, i_host_addr;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned half    = 8;
    int          strobe_cnt, done_cnt, err_cnt;
    logic [12:0] st_addr [$];
    logic [7:0]  st_data [$];

    always #5 clk = ~clk;

    ad9517_spi_target #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_sdio_i(spi_sdio_i),
        .spi_sdio_o(spi_sdio_o), .spi_sdio_oe(spi_sdio_oe),
        .o_wr_strobe(o_wr_strobe), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .i_host_addr(i_host_addr), .o_host_rdata(o_host_rdata),
        .o_frame_done(o_frame_done), .o_frame_err(o_frame_err)
    );

    always @(negedge clk) begin
        if (o_wr_strobe) begin
            strobe_cnt++;
            st_addr.push_back(o_wr_addr);
            st_data.push_back(o_wr_data);
        end
        if (o_frame_done) done_cnt++;
        if (o_frame_err)  err_cnt++;
    end

    task automatic clear_mon();
        strobe_cnt = 0; done_cnt = 0; err_cnt = 0;
        st_addr.delete(); st_data.delete();
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        wait_clk(half);
    endtask

    task automatic cs_high();
        wait_clk(half);
        spi_cs_n = 1'b1;
        wait_clk(12);
    endtask

    task automatic bit_xfer(input logic b, output logic r, output logic oe);
        spi_sdio_i = b;
        wait_clk(half);
        spi_sclk = 1'b1;
        r  = spi_sdio_o;
        oe = spi_sdio_oe;
        wait_clk(half);
        spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic [7:0] r, output int oe_cnt);
        logic rb, ob;
        oe_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(d[i], rb, ob);
            r[i] = rb;
            if (ob) oe_cnt++;
        end
    endtask

    task automatic send_hdr(input logic [15:0] h, output int oe_cnt);
        logic [7:0] r;
        int         c0, c1;
        send_byte(h[15:8], r, c0);
        send_byte(h[7:0], r, c1);
        oe_cnt = c0 + c1;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        i_host_addr = a;
        @(negedge clk);
        d = o_host_rdata;
    endtask

    task automatic write1(input logic [12:0] a, input logic [7:0] d);
        logic [7:0] r;
        int         c;
        cs_low();
        send_hdr({3'b000, a}, c);
        send_byte(d, r, c);
        cs_high();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_sdio_i = 1'b0; i_host_addr = '0;
        clear_mon();
        wait_clk(3);
        n_tests++; if ({spi_sdio_oe, spi_sdio_o, o_wr_strobe, o_frame_done, o_frame_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                {spi_sdio_oe, spi_sdio_o, o_wr_strobe, o_frame_done, o_frame_err}); end
        n_tests++; if ({o_wr_addr, o_wr_data, o_host_rdata} !== 29'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {o_wr_addr, o_wr_data, o_host_rdata}); end
        rst = 1'b0;
        wait_clk(10);
        n_tests++; if (done_cnt + err_cnt !== 0) begin
            n_fail++; $display("FAIL reset_pulses: got %0d expected 0", done_cnt + err_cnt); end
        host_read(8'h10, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_mem: got %h expected 00", d); end
    endtask

    task automatic test_single_write();
        logic [7:0] d;
        clear_mon();
        write1(13'h0010, 8'hA5);
        n_tests++; if (strobe_cnt !== 1) begin n_fail++; $display("FAIL w1_strobes: got %0d expected 1", strobe_cnt); end
        n_tests++; if (st_addr[0] !== 13'h0010 || st_data[0] !== 8'hA5) begin
            n_fail++; $display("FAIL w1_strobe_val: got %h/%h expected 0010/a5", st_addr[0], st_data[0]); end
        n_tests++; if (done_cnt !== 1 || err_cnt !== 0) begin
            n_fail++; $display("FAIL w1_frame: got done %0d err %0d expected 1/0", done_cnt, err_cnt); end
        host_read(8'h10, d);
        n_tests++; if (d !== 8'hA5) begin n_fail++; $display("FAIL w1_mem: got %h expected a5", d); end
    endtask

    task automatic test_multi_write_readback();
        logic [7:0]  d, r;
        logic [7:0]  exp_d [3] = '{8'h11, 8'h22, 8'h33};
        logic [12:0] exp_a [3] = '{13'h0012, 13'h0011, 13'h0010};
        int          c;
        clear_mon();
        cs_low();
        send_hdr(16'h4012, c);
        for (int i = 0; i < 3; i++) send_byte(exp_d[i], r, c);
        cs_high();
        n_tests++; if (strobe_cnt !== 3) begin n_fail++; $display("FAIL w3_strobes: got %0d expected 3", strobe_cnt); end
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (st_addr[i] !== exp_a[i] || st_data[i] !== exp_d[i]) begin
                n_fail++; $display("FAIL w3_strobe%0d: got %h/%h expected %h/%h", i, st_addr[i], st_data[i], exp_a[i], exp_d[i]); end
            host_read(exp_a[i][7:0], d);
            n_tests++; if (d !== exp_d[i]) begin n_fail++; $display("FAIL w3_mem%0d: got %h expected %h", i, d, exp_d[i]); end
        end
        clear_mon();
        cs_low();
        send_hdr(16'h8012, c);
        n_tests++; if (c !== 0) begin n_fail++; $display("FAIL rd_hdr_oe: got %0d expected 0", c); end
        send_byte(8'h00, r, c);
        n_tests++; if (r !== 8'h11) begin n_fail++; $display("FAIL rd_data: got %h expected 11", r); end
        n_tests++; if (c !== 8) begin n_fail++; $display("FAIL rd_data_oe: got %0d expected 8", c); end
        cs_high();
        n_tests++; if (spi_sdio_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_end: got %b expected 0", spi_sdio_oe); end
        n_tests++; if (done_cnt !== 1 || err_cnt !== 0 || strobe_cnt !== 0) begin
            n_fail++; $display("FAIL rd_frame: got done %0d err %0d strobes %0d expected 1/0/0", done_cnt, err_cnt, strobe_cnt); end
    endtask

    task automatic test_stream_read();
        logic [7:0] d, r;
        logic [7:0] exp_r [3] = '{8'h5A, 8'hC3, 8'h00};
        int         c;
        write1(13'h00FF, 8'h77);
        cs_low();
        send_hdr(16'h2001, c);
        send_byte(8'h5A, r, c);
        send_byte(8'hC3, r, c);
        cs_high();
        clear_mon();
        write1(13'h0100, 8'hEE);
        n_tests++; if (strobe_cnt !== 1 || st_addr[0] !== 13'h0100 || st_data[0] !== 8'hEE) begin
            n_fail++; $display("FAIL oor_strobe: got %0d %h/%h expected 1 0100/ee", strobe_cnt, st_addr[0], st_data[0]); end
        host_read(8'h00, d);
        n_tests++; if (d !== 8'hC3) begin n_fail++; $display("FAIL oor_discard: got %h expected c3", d); end
        clear_mon();
        cs_low();
        send_hdr(16'hE001, c);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00, r, c);
            n_tests++; if (r !== exp_r[i] || c !== 8) begin
                n_fail++; $display("FAIL stream_byte%0d: got %h oe %0d expected %h oe 8", i, r, c, exp_r[i]); end
        end
        cs_high();
        n_tests++; if (done_cnt !== 1 || err_cnt !== 0) begin
            n_fail++; $display("FAIL stream_frame: got done %0d err %0d expected 1/0", done_cnt, err_cnt); end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic       rb, ob;
        int         c, k;
        clear_mon();
        cs_low();
        send_hdr(16'h0020, c);
        for (int i = 0; i < 5; i++) bit_xfer(1'b1, rb, ob);
        cs_high();
        n_tests++; if (strobe_cnt !== 0 || err_cnt !== 1 || done_cnt !== 0) begin
            n_fail++; $display("FAIL abort_w: got strobes %0d err %0d done %0d expected 0/1/0", strobe_cnt, err_cnt, done_cnt); end
        host_read(8'h20, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL abort_mem: got %h expected 00", d); end
        clear_mon();
        cs_low();
        send_hdr(16'h8010, c);
        for (int i = 0; i < 3; i++) bit_xfer(1'b0, rb, ob);
        wait_clk(half);
        n_tests++; if (spi_sdio_oe !== 1'b1) begin n_fail++; $display("FAIL abort_oe_pre: got %b expected 1", spi_sdio_oe); end
        spi_cs_n = 1'b1;
        k = 0;
        while (k < 4 && spi_sdio_oe !== 1'b0) begin
            @(posedge clk); #1;
            k++;
        end
        n_tests++; if (spi_sdio_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe_drop: got %b after %0d clk expected 0", spi_sdio_oe, k); end
        wait_clk(12);
        n_tests++; if (err_cnt !== 1 || done_cnt !== 0) begin
            n_fail++; $display("FAIL abort_r: got err %0d done %0d expected 1/0", err_cnt, done_cnt); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] d, r;
        logic       rb, ob;
        int         c;
        clear_mon();
        cs_low();
        send_hdr(16'h8012, c);
        for (int i = 0; i < 3; i++) bit_xfer(1'b0, rb, ob);
        rst = 1'b1;
        wait_clk(2);
        n_tests++; if (spi_sdio_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b expected 0", spi_sdio_oe); end
        rst = 1'b0;
        send_byte(8'hFF, r, c);
        n_tests++; if (c !== 0 || strobe_cnt !== 0) begin
            n_fail++; $display("FAIL rst_ignore: got oe %0d strobes %0d expected 0/0", c, strobe_cnt); end
        cs_high();
        n_tests++; if (done_cnt !== 0 || err_cnt !== 0) begin
            n_fail++; $display("FAIL rst_pulses: got done %0d err %0d expected 0/0", done_cnt, err_cnt); end
        host_read(8'h12, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_mem12: got %h expected 00", d); end
        host_read(8'hFF, d);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_memff: got %h expected 00", d); end
        write1(13'h0030, 8'h3C);
        host_read(8'h30, d);
        n_tests++; if (d !== 8'h3C || strobe_cnt !== 1 || done_cnt !== 1) begin
            n_fail++; $display("FAIL rst_recover: got %h strobes %0d done %0d expected 3c/1/1", d, strobe_cnt, done_cnt); end
    endtask

    task automatic test_loopback();
        logic [7:0] d;
        logic [7:0] la [4] = '{8'h05, 8'h06, 8'h80, 8'hFE};
        logic [7:0] ld [4] = '{8'h9C, 8'h3E, 8'h01, 8'hF0};
        clear_mon();
        half = 32;
        for (int i = 0; i < 4; i++) write1({5'b0, la[i]}, ld[i]);
        half = 8;
        n_tests++; if (strobe_cnt !== 4 || done_cnt !== 4 || err_cnt !== 0) begin
            n_fail++; $display("FAIL loop_frames: got strobes %0d done %0d err %0d expected 4/4/0", strobe_cnt, done_cnt, err_cnt); end
        for (int i = 0; i < 4; i++) begin
            host_read(la[i], d);
            n_tests++; if (d !== ld[i]) begin n_fail++; $display("FAIL loop_mem%0d: got %h expected %h", i, d, ld[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_multi_write_readback();
        test_stream_read();
        test_abort();
        test_reset_mid_read();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
